// File: rtl/queue_loader.sv
// rtl/queue_loader.sv - write-side controller for the calculator command byte queue
module queue_loader #(
  parameter int DEPTH = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       pop_en,
  input  logic       pop_two,
  output logic       pop_ok,
  output logic       extra_out,
  output logic [7:0] back,
  output logic [2:0] pos_back,
  output logic       wr_en,
  output logic [2:0] count,
  output logic       underflow
);

  localparam logic [2:0] DEPTH_W = 3'(DEPTH);

  logic [2:0] count_q;
  logic       hold_valid;
  logic [7:0] hold_data;
  logic       underflow_q;

  logic [2:0] need;
  logic       pop_ok_c;
  logic [2:0] pop_amt;
  logic [2:0] base;
  logic       commit;
  logic       ready_c;
  logic       accept;

  // Post-pop slot and commit decision; outputs are forced to zero while in reset.
  always_comb begin
    need      = pop_two ? 3'd2 : 3'd1;
    pop_ok_c  = pop_en && (count_q >= need);
    pop_amt   = pop_ok_c ? need : 3'd0;
    base      = count_q - pop_amt;
    commit    = hold_valid && (base < DEPTH_W);
    ready_c   = !rst && (!hold_valid || commit);
    accept    = in_valid && ready_c;

    in_ready  = ready_c;
    pop_ok    = !rst && pop_ok_c;
    extra_out = !rst && pop_ok_c && pop_two;
    wr_en     = !rst && commit;
    back      = (!rst && commit) ? hold_data : 8'd0;
    pos_back  = (!rst && commit) ? base : 3'd0;
    count     = rst ? 3'd0 : count_q;
    underflow = !rst && underflow_q;
  end

  // Occupancy mirror, one-deep skid holding register and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 3'd0;
      hold_valid  <= 1'b0;
      hold_data   <= 8'd0;
      underflow_q <= 1'b0;
    end else begin
      count_q    <= base + {2'b00, commit};
      hold_valid <= accept || (hold_valid && !commit);
      if (accept) begin
        hold_data <= in_data;
      end
      if (pop_en && !pop_ok_c) begin
        underflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_queue_loader.sv
// tb/tb_queue_loader.sv - scoreboard bench for queue_loader with a queue-level reference model
module tb_queue_loader;

  localparam int DEPTH = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       pop_en;
  logic       pop_two;
  logic       pop_ok;
  logic       extra_out;
  logic [7:0] back;
  logic [2:0] pos_back;
  logic       wr_en;
  logic [2:0] count;
  logic       underflow;

  queue_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .pop_en(pop_en), .pop_two(pop_two), .pop_ok(pop_ok), .extra_out(extra_out),
    .back(back), .pos_back(pos_back), .wr_en(wr_en),
    .count(count), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;

  // Reference model: bytes stored in the queue, bytes waiting upstream of it.
  int         m_cnt;
  bit         m_uf;
  logic [7:0] m_hold[$];
  logic [7:0] exp_wr[$];
  logic [7:0] exp_pop[$];
  logic [7:0] arr[8];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d,
                      input logic pe, input logic pt);
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_data = d; pop_en = pe; pop_two = pt;
    #3;
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_uf  = 1'b0;
    m_hold.delete();
    exp_wr.delete();
    exp_pop.delete();
    for (int i = 0; i < 8; i++) arr[i] = 8'd0;
  endtask

  task automatic monitor_cycle();
    int  need, take, e_base;
    bit  e_pok, e_commit, e_ready;
    logic [7:0] e_back;
    @(negedge clk);
    if (rst) begin
      check("reset_outputs", {in_ready, pop_ok, extra_out, wr_en, back, pos_back, count, underflow}, 0);
      model_reset();
    end else begin
      need     = pop_two ? 2 : 1;
      e_pok    = pop_en && (m_cnt >= need);
      e_base   = m_cnt - (e_pok ? need : 0);
      e_commit = (m_hold.size() != 0) && (e_base < DEPTH);
      e_ready  = (m_hold.size() == 0) || e_commit;
      e_back   = e_commit ? m_hold[0] : 8'd0;

      check("pop_ok", pop_ok, e_pok);
      check("extra_out", extra_out, e_pok && pop_two);
      check("wr_en", wr_en, e_commit);
      check("back", back, e_back);
      check("pos_back", pos_back, e_commit ? e_base : 0);
      check("in_ready", in_ready, e_ready);
      check("count", count, m_cnt);
      check("count_max", count <= 3'(DEPTH), 1);
      check("underflow", underflow, m_uf);

      // Downstream queue driven from the DUT outputs: shift out, then write.
      if (pop_ok) begin
        take = extra_out ? 2 : 1;
        for (int k = 0; k < take; k++) begin
          if (exp_pop.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL pop_order: got %0h expected nothing", arr[0]);
          end else begin
            check("pop_order", arr[0], exp_pop.pop_front());
          end
          for (int i = 0; i < 7; i++) arr[i] = arr[i+1];
        end
      end
      if (wr_en) begin
        if (exp_wr.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL wr_data: got %0h expected no write", back);
        end else begin
          check("wr_data", back, exp_wr.pop_front());
        end
        arr[pos_back] = back;
      end

      if (pop_en && !e_pok) m_uf = 1'b1;
      if (e_commit) void'(m_hold.pop_front());
      m_cnt = e_base + (e_commit ? 1 : 0);
      if (in_valid && e_ready) begin
        m_hold.push_back(in_data);
        exp_wr.push_back(in_data);
        exp_pop.push_back(in_data);
        n_acc++;
      end
    end
  endtask

  initial begin
    int acc0;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; pop_en = 1'b0; pop_two = 1'b0;
    model_reset();
    fork
      forever monitor_cycle();
      begin
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);

        // Fill from empty.
        step(0, 1, 8'hA1, 0, 0);
        check("first_ready", in_ready, 1);
        check("first_count", count, 0);
        for (int k = 1; k <= 5; k++) begin
          step(0, 1, 8'(8'hA1 + k), 0, 0);
          check("fill_wr_en", wr_en, 1);
          check("fill_pos", pos_back, k - 1);
          check("fill_back", back, 8'hA1 + k - 1);
        end
        step(0, 0, 8'h00, 0, 0);
        check("full_in_ready", in_ready, 0);
        check("full_wr_en", wr_en, 0);
        check("full_count", count, 5);

        // Full with a 1-byte pop.
        step(0, 0, 8'h00, 1, 0);
        check("full_pop_ok", pop_ok, 1);
        check("full_pop_extra", extra_out, 0);
        check("full_pop_wr", wr_en, 1);
        check("full_pop_back", back, 8'hA6);
        check("full_pop_pos", pos_back, 4);
        step(0, 0, 8'h00, 0, 0);
        check("after_pop_count", count, 5);
        check("after_pop_ready", in_ready, 1);

        // Underflow.
        step(0, 0, 8'h00, 1, 1);
        step(0, 0, 8'h00, 1, 1);
        step(0, 0, 8'h00, 1, 1);
        check("uf_pop_ok", pop_ok, 0);
        check("uf_extra", extra_out, 0);
        check("uf_count", count, 1);
        step(0, 0, 8'h00, 0, 0);
        check("uf_set", underflow, 1);
        check("uf_count_kept", count, 1);
        step(0, 0, 8'h00, 0, 0);
        check("uf_sticky", underflow, 1);

        // Simultaneous pop and write.
        step(0, 1, 8'h11, 0, 0);
        step(0, 1, 8'h22, 0, 0);
        step(0, 1, 8'h5C, 0, 0);
        step(0, 0, 8'h00, 1, 1);
        check("sim_pos", pos_back, 1);
        check("sim_back", back, 8'h5C);
        check("sim_extra", extra_out, 1);
        step(0, 0, 8'h00, 0, 0);
        check("sim_count", count, 2);

        // Reset mid-operation with a byte held.
        step(0, 1, 8'h33, 0, 0);
        step(0, 1, 8'h44, 0, 0);
        step(0, 1, 8'h55, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        check("pre_rst_count", count, 4);
        check("pre_rst_uf", underflow, 1);
        step(1, 0, 8'h00, 0, 0);
        check("in_rst_ready", in_ready, 0);
        step(0, 0, 8'h00, 0, 0);
        check("post_rst_count", count, 0);
        check("post_rst_wr", wr_en, 0);
        check("post_rst_uf", underflow, 0);
        check("post_rst_ready", in_ready, 1);
        step(0, 0, 8'h00, 0, 0);
        check("post_rst_no_write", wr_en, 0);

        // Streaming: 20 random bytes with random pops, then drain.
        acc0 = n_acc;
        for (int c = 0; c < 600 && ((n_acc - acc0) < 20 || exp_pop.size() != 0); c++) begin
          step(0, ((n_acc - acc0) < 20) && ($urandom_range(0, 3) != 0), 8'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check("stream_accepted", (n_acc - acc0) >= 20, 1);
        check("stream_drained", exp_pop.size(), 0);
        step(0, 0, 8'h00, 0, 0);
        @(negedge clk);
        #1;
      end
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/queue_loader.md
# queue_loader

Write-side controller for the 5-entry byte queue used by the calculator command path. It accepts a byte stream over a valid/ready handshake and buffers one byte in a holding register. It mirrors the queue's occupancy and issues one write per cycle at the correct slot (`back`, `pos_back`), taking into account the 1- or 2-byte pop (`extra_out`) the queue performs in the same cycle. It also rejects pops that would underflow and reports them.

## Interface
- `DEPTH`, 5: number of queue byte slots; `pos_back` and `count` are 3 bits wide, sized for `DEPTH` ≤ 7.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `in_data` input 8: byte from the upstream stream.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts `in_data` this cycle.
- `pop_en` input 1: consumer requests a pop this cycle.
- `pop_two` input 1: when `pop_en` is high, 1 requests a 2-byte pop and 0 a 1-byte pop.
- `pop_ok` output 1: the requested pop is accepted this cycle. Combinational.
- `extra_out` output 1: pop size to the queue (1 = two bytes). Equals `pop_two` when `pop_ok` is high, else 0.
- `back` output 8: byte written to the queue, from the holding register.
- `pos_back` output 3: slot index for `back`.
- `wr_en` output 1: `back`/`pos_back` are valid this cycle.
- `count` output 3: registered occupancy, 0..`DEPTH`.
- `underflow` output 1: sticky flag, set by any rejected pop.

## Operation
- State: `count`, `hold_valid`, `hold_data` (8 bits), `underflow`.
- Pop amount `need` = 2 if `pop_two`, else 1.
- `pop_ok` = `pop_en` && `count` ≥ `need`.
- `p` = `pop_ok` ? `need` : 0.
- `base` = `count` − `p`. Never negative by construction.
- Commit condition `commit` = `hold_valid` && `base` < `DEPTH`.
- When `commit` is high:
  - `wr_en` = 1, `back` = `hold_data`, `pos_back` = `base`.
- When `commit` is low:
  - `wr_en` = 0, `back` = 0, `pos_back` = 0.
- `in_ready` = !`rst` && (!`hold_valid` || `commit`). The holding register is a one-deep skid with full throughput.
- Next state:
  - `count` ← `base` + `commit`.
  - `hold_valid` ← (`in_valid` && `in_ready`) || (`hold_valid` && !`commit`).
  - `hold_data` ← `in_data` when (`in_valid` && `in_ready`), else unchanged.
- Rejected pop (`pop_en` && !`pop_ok`):
  - `count` is unchanged by the pop.
  - `extra_out` = 0.
  - `underflow` ← 1 and stays set until reset.
- Simultaneous pop and commit in the same cycle is legal. The byte lands at the post-pop position.
- At `count` = `DEPTH` with no pop, the held byte waits and `in_ready` = 0.
- Bytes are written in acceptance order; there is no reordering or dropping.
- Reset (any cycle, including mid-transfer): `count` = 0, `hold_valid` = 0, `hold_data` = 0, `underflow` = 0. Any held byte is discarded.

## Timing
- Input acceptance to `wr_en`: 1 cycle minimum, more while the queue is full.
- Sustained throughput: 1 byte/cycle when pops keep `base` < `DEPTH`.
- `pop_ok`, `extra_out`, `wr_en`, `back`, `pos_back` and `in_ready` are combinational from the current state and `pop_en`/`pop_two`.
- `count` and `underflow` are registered.
- A change in `count` is visible 1 cycle after the pop/commit that causes it.
- While `rst` is high, all outputs are 0, including `in_ready`. `in_ready` = 1 in the first cycle after `rst` is deasserted.
- The queue must perform its shift and its `arr[pos_back]` write on the same edge as this block's state update.

## Test plan
- Fill from empty:
  - Stimulus: reset, then bytes 0xA1..0xA5 back-to-back, no pops.
  - Response: `wr_en` on cycles 1..5 after the first acceptance with `pos_back` 0,1,2,3,4, then `count` = 5.
  - Stimulus: sixth byte 0xA6 is accepted into hold.
  - Response: `in_ready` = 0, `wr_en` = 0.
- Full with a 1-byte pop:
  - Stimulus: state from the previous test, assert `pop_en` = 1, `pop_two` = 0.
  - Response: `pop_ok` = 1, `extra_out` = 0, `wr_en` = 1, `back` = 0xA6, `pos_back` = 4; next cycle `count` = 5 and `in_ready` = 1.
- Underflow:
  - Stimulus: `count` = 1, assert `pop_en` = 1, `pop_two` = 1.
  - Response: `pop_ok` = 0, `extra_out` = 0, `count` stays 1, `underflow` = 1 next cycle and remains set.
- Simultaneous pop and write:
  - Stimulus: `count` = 3, byte 0x5C held, assert a 2-byte pop.
  - Response: `pos_back` = 1, `back` = 0x5C, `extra_out` = 1; next cycle `count` = 2.
- Reset mid-operation:
  - Stimulus: `count` = 4, byte held, `underflow` = 1, assert `rst` for 1 cycle.
  - Response: next cycle `count` = 0, `wr_en` = 0, `underflow` = 0, `in_ready` = 1; the held byte is never written.
- Streaming:
  - Stimulus: 20 random bytes with random 1/2-byte pops.
  - Response: the queue model's pop order equals input order, `count` matches the model every cycle, and `count` never exceeds 5.
